// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: issues PC-driven requests to a variable-latency imem and queues
// tagged returns for decode. Optional perf counters behind `IF_FETCH_PERF_EN.
module if_fetch_buffer #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_advance,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rdy,
  input  logic [DW-1:0] imem_rdata,
  input  logic          flush,
  output logic          inst_valid,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  input  logic          dec_ready
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   squash_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } entry_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic [AW-1:0] addr_q;
  entry_t        mem [DEPTH];
  logic          full, push, pop, discard;

  assign full       = (count == (PW+1)'(DEPTH));
  assign inst_valid = (count != '0);
  assign inst       = mem[rd_ptr].data;
  assign inst_pc    = mem[rd_ptr].pc;
  assign pop        = inst_valid & dec_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!full && !flush && !imem_rdy) state_nxt = WAIT;
      WAIT:    if (imem_rdy) state_nxt = IDLE;
               else if (flush) state_nxt = SQUASH;
      SQUASH:  if (imem_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even though IDLE would otherwise request.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    pc_advance = 1'b0;
    push       = 1'b0;
    discard    = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          imem_req   = ~full & ~flush;
          imem_addr  = pc_addr;
          push       = ~full & ~flush & imem_rdy;
          pc_advance = ~full & ~flush & imem_rdy;
        end
        WAIT: begin
          imem_req   = 1'b1;
          imem_addr  = addr_q;
          push       = imem_rdy & ~flush;
          pc_advance = imem_rdy & ~flush;
          discard    = imem_rdy & flush;
        end
        SQUASH: begin
          imem_req   = 1'b1;
          imem_addr  = addr_q;
          discard    = imem_rdy;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      addr_q <= '0;
    end else begin
      if (state == IDLE && state_nxt == WAIT) addr_q <= pc_addr;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  // A push never lands on the head slot while it is valid, so the head holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{pc: imem_addr, data: imem_rdata};
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (!pc_advance && stall_cnt != 16'hFFFF) stall_cnt  <= stall_cnt + 16'd1;
      if (discard && squash_cnt != 16'hFFFF)    squash_cnt <= squash_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Randomized + directed bench for if_fetch_buffer against a queue-based fetch model.
module tb_if_fetch_buffer;
  localparam int AW = 16, DW = 16, DEPTH = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] pc_addr = '0, imem_addr, inst_pc;
  logic [DW-1:0] imem_rdata = '0, inst;
  logic          pc_advance, imem_req, imem_rdy = 1'b0, flush = 1'b0, inst_valid, dec_ready = 1'b0;
`ifdef IF_FETCH_PERF_EN
  logic [15:0]   stall_cnt, squash_cnt;
`endif

  if_fetch_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .flush(flush), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready)
`ifdef IF_FETCH_PERF_EN
    , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: FIFO contents as a queue, plus one outstanding request that may be marked squashed.
  typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
  ent_t        q[$];
  bit          pend, sq;
  logic [15:0] paddr, pc;
  int unsigned m_stall, m_squash;
  bit          e_req, e_adv, e_vld;
  logic [15:0] e_addr;
  logic [18:0] e_ctl;
  logic [31:0] e_head;
  int          nvec, nerr;

  task automatic drive(input bit rdy, input bit dec, input bit fl, input logic [15:0] rd);
    @(negedge clk);
    imem_rdy = rdy; dec_ready = dec; flush = fl; imem_rdata = rd; pc_addr = pc;
    #2;
    if (!pend) begin
      e_req = (q.size() < DEPTH) && !fl; e_addr = pc; e_adv = e_req && rdy;
    end else begin
      e_req = 1'b1; e_addr = paddr; e_adv = !sq && rdy && !fl;
    end
    e_vld  = q.size() != 0;
    e_head = e_vld ? {q[0].a, q[0].d} : 32'h0;
    e_ctl  = {e_req, e_addr, e_adv, e_vld};
  endtask

  task automatic step();
    @(posedge clk);
    if (!e_adv) m_stall++;
    if (pend && imem_rdy && (sq || flush)) m_squash++;
    if (flush) begin
      q.delete();
      if (pend) begin
        if (imem_rdy) pend = 1'b0; else sq = 1'b1;
      end
    end else begin
      if (e_vld && dec_ready) void'(q.pop_front());
      if (!pend) begin
        if (e_req && imem_rdy) q.push_back('{pc, imem_rdata});
        else if (e_req) begin pend = 1'b1; sq = 1'b0; paddr = pc; end
      end else if (imem_rdy) begin
        if (!sq) q.push_back('{paddr, imem_rdata});
        pend = 1'b0;
      end
    end
    if (e_adv) pc++;
  endtask

  task automatic test_reset();
    pc_addr = 16'h1234; imem_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      nvec++;
      if ({pc_advance, imem_req, imem_addr, inst_valid, inst, inst_pc} !== 50'h0) begin
        nerr++;
        $display("FAIL reset%0d got adv=%b req=%b addr=%h vld=%b inst=%h pc=%h exp all 0",
                 i, pc_advance, imem_req, imem_addr, inst_valid, inst, inst_pc);
      end
      @(posedge clk);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_stream();
    pc = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, i == 4, 16'hA000 | pc);
      nvec++;
      if ({imem_req, imem_addr, pc_advance, inst_valid} !== e_ctl || (e_vld && {inst_pc, inst} !== e_head)) begin
        nerr++;
        $display("FAIL stream%0d got ctl=%h head=%h exp ctl=%h head=%h", i,
                 {imem_req, imem_addr, pc_advance, inst_valid}, {inst_pc, inst}, e_ctl, e_head);
      end
      if (i >= 1) begin
        nvec++;
        if (inst_pc !== 16'(i - 1) || inst !== (16'hA000 | 16'(i - 1))) begin
          nerr++;
          $display("FAIL stream_head%0d got %h/%h exp %h/%h", i, inst_pc, inst, 16'(i - 1), 16'hA000 | 16'(i - 1));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    pc = 16'h0010;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i >= 4, i == 8, 16'hB000 | pc);
      nvec++;
      if ({imem_req, imem_addr, pc_advance, inst_valid} !== e_ctl || (e_vld && {inst_pc, inst} !== e_head)) begin
        nerr++;
        $display("FAIL backpr%0d got ctl=%h head=%h exp ctl=%h head=%h", i,
                 {imem_req, imem_addr, pc_advance, inst_valid}, {inst_pc, inst}, e_ctl, e_head);
      end
      step();
    end
  endtask

  task automatic test_wait();
    pc = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      drive(i >= 3, 1'b1, i == 4, 16'hC020);
      nvec++;
      if ({imem_req, imem_addr, pc_advance, inst_valid} !== e_ctl || (e_vld && {inst_pc, inst} !== e_head)) begin
        nerr++;
        $display("FAIL wait%0d got ctl=%h head=%h exp ctl=%h head=%h", i,
                 {imem_req, imem_addr, pc_advance, inst_valid}, {inst_pc, inst}, e_ctl, e_head);
      end
      step();
    end
  endtask

  task automatic test_flush_wait();
    pc = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      drive(i >= 3, 1'b1, i == 1 || i == 5, (i == 3) ? 16'hDEAD : 16'hA030);
      nvec++;
      if ({imem_req, imem_addr, pc_advance, inst_valid} !== e_ctl || (e_vld && {inst_pc, inst} !== e_head)
          || (inst_valid && inst === 16'hDEAD)) begin
        nerr++;
        $display("FAIL flush_wait%0d got ctl=%h head=%h exp ctl=%h head=%h", i,
                 {imem_req, imem_addr, pc_advance, inst_valid}, {inst_pc, inst}, e_ctl, e_head);
      end
      step();
    end
`ifdef IF_FETCH_PERF_EN
    nvec++;
    if (squash_cnt !== 16'(m_squash)) begin
      nerr++; $display("FAIL squash_cnt got %0d exp %0d", squash_cnt, m_squash);
    end
`endif
  endtask

  task automatic test_flush_full();
    pc = 16'h0040;
    for (int i = 0; i < 5; i++) begin
      drive(i != 2, i >= 2, i == 2 || i == 4, 16'hB000 | pc);
      nvec++;
      if ({imem_req, imem_addr, pc_advance, inst_valid} !== e_ctl || (e_vld && {inst_pc, inst} !== e_head)) begin
        nerr++;
        $display("FAIL flush_full%0d got ctl=%h head=%h exp ctl=%h head=%h", i,
                 {imem_req, imem_addr, pc_advance, inst_valid}, {inst_pc, inst}, e_ctl, e_head);
      end
      step();
      if (i == 2) pc = 16'h0100;
    end
  endtask

  task automatic test_reset_mid();
    pc = 16'h0050;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    step();
    #3 rst_n = 1'b0;
    #1;
    nvec++;
    if ({pc_advance, imem_req, imem_addr, inst_valid, inst, inst_pc} !== 50'h0) begin
      nerr++;
      $display("FAIL reset_mid got adv=%b req=%b addr=%h vld=%b inst=%h pc=%h exp all 0",
               pc_advance, imem_req, imem_addr, inst_valid, inst, inst_pc);
    end
`ifdef IF_FETCH_PERF_EN
    nvec++;
    if ({stall_cnt, squash_cnt} !== 32'h0) begin
      nerr++; $display("FAIL reset_cnt got %h/%h exp 0/0", stall_cnt, squash_cnt);
    end
`endif
    q.delete(); pend = 1'b0; sq = 1'b0; m_stall = 0; m_squash = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    pc = 16'h0060;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, i == 1, 16'hD060);
      nvec++;
      if ({imem_req, imem_addr, pc_advance, inst_valid} !== e_ctl || (e_vld && {inst_pc, inst} !== e_head)) begin
        nerr++;
        $display("FAIL reset_rel%0d got ctl=%h head=%h exp ctl=%h head=%h", i,
                 {imem_req, imem_addr, pc_advance, inst_valid}, {inst_pc, inst}, e_ctl, e_head);
      end
      step();
    end
  endtask

  task automatic test_random();
    bit fl;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom % 16) == 0;
      drive(($urandom % 10) < 7, ($urandom % 10) < 6, fl, 16'($urandom));
      nvec++;
      if ({imem_req, imem_addr, pc_advance, inst_valid} !== e_ctl || (e_vld && {inst_pc, inst} !== e_head)) begin
        nerr++;
        $display("FAIL random%0d got ctl=%h head=%h exp ctl=%h head=%h", i,
                 {imem_req, imem_addr, pc_advance, inst_valid}, {inst_pc, inst}, e_ctl, e_head);
      end
      step();
      if (fl) pc = 16'($urandom);
    end
`ifdef IF_FETCH_PERF_EN
    #2;
    nvec++;
    if (stall_cnt !== 16'(m_stall) || squash_cnt !== 16'(m_squash)) begin
      nerr++;
      $display("FAIL perf_cnt got stall=%0d squash=%0d exp stall=%0d squash=%0d",
               stall_cnt, squash_cnt, m_stall, m_squash);
    end
`endif
  endtask

  initial begin
    nvec = 0; nerr = 0; pend = 1'b0; sq = 1'b0; paddr = '0; pc = '0; m_stall = 0; m_squash = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wait();
    test_flush_wait();
    test_flush_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
Instruction fetch buffer that sits directly downstream of the program counter. It takes the current fetch address and issues requests to a variable-latency instruction memory. Returned instructions, tagged with their fetch address, are queued in a small FIFO for decode. It drives back-pressure to the PC (advance/stall) and squashes in-flight and queued instructions on a taken branch.

Parameters:
AW, 16, instruction address width
DW, 16, instruction word width
DEPTH, 2, buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pc_addr  in  AW  current fetch address from PC
pc_advance  out  1  PC may move to next address this cycle
imem_req  out  1  instruction memory request
imem_addr  out  AW  request address, stable while imem_req high
imem_rdy  in  1  memory accepts/returns this cycle (may be same cycle as req)
imem_rdata  in  DW  instruction data, valid when imem_req & imem_rdy
flush  in  1  taken branch: discard queued and in-flight instructions
inst_valid  out  1  head entry valid
inst  out  DW  head instruction
inst_pc  out  AW  address of head instruction
dec_ready  in  1  decode consumes head this cycle

Behaviour:
- Reset: state IDLE; count=0; rd/wr pointers=0; imem_req=0; pc_advance=0; inst_valid=0; inst, inst_pc and latched address=0. Reset mid-request abandons it with no squash tracking.
- States: IDLE, WAIT, SQUASH.
- full = (count==DEPTH), using the registered count. A pop in the same cycle does not free a slot for a push.
- IDLE: imem_req = !full & !flush; imem_addr = pc_addr.
  - req & rdy: push {pc_addr, imem_rdata}; pc_advance=1; stay IDLE. Throughput is 1 instruction/cycle.
  - req & !rdy: latch pc_addr; go WAIT; pc_advance=0.
- WAIT: imem_req=1; imem_addr = latched address.
  - rdy & !flush: push; pc_advance=1; go IDLE.
  - flush & !rdy: go SQUASH.
  - flush & rdy: discard data; go IDLE.
- SQUASH: imem_req=1 (a request cannot be withdrawn); on rdy, discard data and go IDLE; pc_advance=0.
- pc_advance is asserted only on a non-squashed push. The PC holds its address whenever pc_advance=0.
- Flush cycle: count, rd_ptr and wr_ptr cleared next edge; no push and no pop that cycle; pc_advance=0. Flush in IDLE issues no request that cycle.
- Pop = inst_valid & dec_ready & !flush; rd_ptr++ (wraps modulo DEPTH). Push: wr_ptr++ (wraps). count tracks push-pop; a simultaneous push and pop leaves count unchanged.
- inst_valid = (count!=0); inst and inst_pc driven from the head entry. No bypass: a pushed instruction is visible the next cycle, so latency is 1 cycle after rdy.
- Head outputs hold stable while inst_valid & !dec_ready.

Optional Feature:
IF_FETCH_PERF_EN.
- Defined: adds output ports stall_cnt (16) and squash_cnt (16).
  - stall_cnt increments every cycle with pc_advance=0.
  - squash_cnt increments once per discarded memory response (WAIT+flush+rdy, or SQUASH+rdy).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Zero-wait stream: rdy=1, dec_ready=1, pc_addr 0x0000..0x0003, rdata 0xA000..0xA003 -> pc_advance=1 every cycle; inst/inst_pc = 0xA000/0x0000 one cycle later, then one per cycle.
- Back-pressure: dec_ready=0, rdy=1 -> two pushes (0x0010, 0x0011), then imem_req=0 and pc_advance=0. Raise dec_ready -> 0x0010 pops first, and the request resumes the cycle after count<2.
- Wait states: rdy low for 3 cycles at pc_addr=0x0020 -> imem_addr holds 0x0020, pc_advance=0 for 3 cycles, then 1 on the rdy cycle; inst_pc=0x0020 next cycle.
- Flush in WAIT: request 0x0030 outstanding, flush pulse, rdy 2 cycles later with 0xDEAD -> SQUASH; 0xDEAD never appears on inst; inst_valid=0; pc_advance=0 until back in IDLE; squash_cnt=1 when the macro is defined.
- Flush with full buffer and simultaneous dec_ready -> no pop counted; count=0 and inst_valid=0 next cycle; the next fetch at new pc_addr 0x0100 delivers inst_pc=0x0100.
- Async reset asserted mid-WAIT -> all outputs 0 immediately; after release, the first request uses the current pc_addr.
